// File: rtl/reduce_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reduce_port_arbiter
//  Purpose  : Round-robin scheduler that shares the node's single reduce FIFO
//             and reduce unit between the four per-direction reduce FIFOs
//             (xpos, ypos, xneg, yneg) and the local reduce_me injection.
//             The local port wins by default but is limited to
//             MAX_LOCAL_BURST consecutive grants while any port is waiting.
//  Ports    : clk, rst (async, active-low)
//             port_empty/port_head  -> four direction FIFO heads
//             port_consume          <- one-hot pop strobe (combinational)
//             local_flit            -> local injection, valid at VALID_BIT_POS
//             local_ready           <- local flit accepted (combinational)
//             sink_afull            -> reduce FIFO almost-full
//             out_flit/out_valid/out_src <- registered write to reduce FIFO
//             grant_cnt             <- wrapping count of grants since reset
//  Revision : 1.0  initial release
// ============================================================================
module reduce_port_arbiter #(
    parameter int FLIT_CHILD_WIDTH = 85,
    parameter int VALID_BIT_POS    = 81,
    parameter int MAX_LOCAL_BURST  = 4,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    port_empty,
    input  logic [4*FLIT_CHILD_WIDTH-1:0] port_head,
    output logic [3:0]                    port_consume,
    input  logic [FLIT_CHILD_WIDTH-1:0]   local_flit,
    output logic                          local_ready,
    input  logic                          sink_afull,
    output logic [FLIT_CHILD_WIDTH-1:0]   out_flit,
    output logic                          out_valid,
    output logic [2:0]                    out_src,
    output logic [CNT_WIDTH-1:0]          grant_cnt
);

    // local_run must be able to hold the value MAX_LOCAL_BURST itself.
    localparam int                 c_RUN_W     = (MAX_LOCAL_BURST < 1) ? 1 : $clog2(MAX_LOCAL_BURST + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX   = c_RUN_W'(MAX_LOCAL_BURST);
    localparam logic [2:0]         c_SRC_LOCAL = 3'd4;

    logic [1:0]                  r_rr_ptr;
    logic [c_RUN_W-1:0]          r_local_run;

    logic [3:0]                  w_port_req;
    logic                        w_any_port_req;
    logic                        w_local_req;
    logic                        w_open;
    logic [1:0]                  w_scan_idx;
    logic [1:0]                  w_port_sel;
    logic                        w_grant_local;
    logic                        w_grant_port;
    logic [FLIT_CHILD_WIDTH-1:0] w_sel_flit;

    assign w_port_req     = ~port_empty;
    assign w_any_port_req = |w_port_req;
    assign w_local_req    = local_flit[VALID_BIT_POS];

    // Gating with rst keeps every pop strobe low while reset is held, so no
    // flit can leave a source FIFO without a matching registered write.
    assign w_open = rst & ~sink_afull;

    // Rotating priority: scan from r_rr_ptr upward.  Iterating from the far
    // end downward lets the nearest requester overwrite earlier candidates.
    always_comb begin
        w_port_sel = r_rr_ptr;
        w_scan_idx = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_scan_idx = r_rr_ptr + 2'(k);
            if (w_port_req[w_scan_idx]) begin
                w_port_sel = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_sel_flit = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_port_sel == 2'(i)) begin
                w_sel_flit = port_head[i*FLIT_CHILD_WIDTH +: FLIT_CHILD_WIDTH];
            end
        end
    end

    // Local keeps the path until it has used up its burst, unless no port is
    // waiting, in which case it may stream indefinitely.
    assign w_grant_local = w_open & w_local_req &
                           ((r_local_run < c_RUN_MAX) | ~w_any_port_req);
    assign w_grant_port  = w_open & w_any_port_req & ~w_grant_local;

    assign port_consume = w_grant_port ? (4'b0001 << w_port_sel) : 4'b0000;
    assign local_ready  = w_grant_local;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= 2'd0;
            r_local_run <= '0;
            out_flit    <= '0;
            out_valid   <= 1'b0;
            out_src     <= 3'd0;
            grant_cnt   <= '0;
        end else begin
            out_valid <= w_grant_local | w_grant_port;
            if (w_grant_local) begin
                out_flit  <= local_flit;
                out_src   <= c_SRC_LOCAL;
                grant_cnt <= grant_cnt + CNT_WIDTH'(1);
                if (r_local_run < c_RUN_MAX) begin
                    r_local_run <= r_local_run + c_RUN_W'(1);
                end
            end else if (w_grant_port) begin
                out_flit    <= w_sel_flit;
                out_src     <= {1'b0, w_port_sel};
                grant_cnt   <= grant_cnt + CNT_WIDTH'(1);
                r_rr_ptr    <= w_port_sel + 2'd1;
                r_local_run <= '0;
            end else if (!sink_afull && !w_local_req) begin
                // Idle cycle: the local burst is over.  Backpressured cycles
                // leave both pointer and burst count untouched.
                r_local_run <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reduce_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reduce_port_arbiter
//  Purpose  : Directed self-checking bench for reduce_port_arbiter.  Source
//             FIFOs are modelled as flit counters with sequence-tagged heads;
//             each step names the source expected to win that cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reduce_port_arbiter;

    localparam int W = 85;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     port_empty;
    logic [4*W-1:0] port_head;
    logic [3:0]     port_consume;
    logic [W-1:0]   local_flit;
    logic           local_ready;
    logic           sink_afull;
    logic [W-1:0]   out_flit;
    logic           out_valid;
    logic [2:0]     out_src;
    logic [15:0]    grant_cnt;

    int           total = 0;
    int           bad   = 0;
    int           cnt  [4];
    int           pseq [4];
    int           lseq;
    bit           local_on;
    logic [W-1:0] last_flit;
    logic [15:0]  exp_cnt;

    reduce_port_arbiter #(
        .FLIT_CHILD_WIDTH (85),
        .VALID_BIT_POS    (81),
        .MAX_LOCAL_BURST  (4),
        .CNT_WIDTH        (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_empty   (port_empty),
        .port_head    (port_head),
        .port_consume (port_consume),
        .local_flit   (local_flit),
        .local_ready  (local_ready),
        .sink_afull   (sink_afull),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .out_src      (out_src),
        .grant_cnt    (grant_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_port(input int p, input int s);
        logic [W-1:0] f;
        f        = '0;
        f[84:82] = 3'(p + 1);
        f[50]    = 1'b1;
        f[15:8]  = 8'(p);
        f[7:0]   = 8'(s);
        return f;
    endfunction

    function automatic logic [W-1:0] mk_local(input int s);
        logic [W-1:0] f;
        f        = '0;
        f[84:82] = 3'd5;
        f[81]    = 1'b1;
        f[15:8]  = 8'h44;
        f[7:0]   = 8'(s);
        return f;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            port_empty[i]          = (cnt[i] == 0);
            port_head[i*W +: W]    = mk_port(i, pseq[i]);
        end
        local_flit = local_on ? mk_local(lseq) : '0;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle.  src = expected winner (0-3 port, 4 local, 7 none).
    task automatic tick(input int src, input bit af);
        logic [W-1:0] ef;
        logic [3:0]   ec;
        sink_afull = af;
        #1;
        ec = (src < 4) ? 4'(1 << src) : 4'd0;
        check("port_consume", W'(port_consume), W'(ec));
        check("local_ready", W'(local_ready), W'(src == 4));
        if (src < 4)       ef = mk_port(src, pseq[src]);
        else if (src == 4) ef = mk_local(lseq);
        else               ef = last_flit;
        @(posedge clk);
        #1;
        if (src <= 4) exp_cnt++;
        check("out_valid", W'(out_valid), W'(src <= 4));
        check("out_flit", out_flit, ef);
        if (src <= 4) check("out_src", W'(out_src), W'(src));
        check("grant_cnt", W'(grant_cnt), W'(exp_cnt));
        last_flit = ef;
        if (src < 4) begin
            cnt[src]--;
            pseq[src]++;
        end else if (src == 4) begin
            lseq++;
        end
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        sink_afull = 1'b0;
        local_on   = 1'b0;
        lseq       = 0;
        last_flit  = '0;
        exp_cnt    = '0;
        for (int i = 0; i < 4; i++) begin
            cnt[i]  = 0;
            pseq[i] = 0;
        end
        drive();

        // Reset state and strobe gating while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_grant_cnt", W'(grant_cnt), W'(0));
        check("rst_out_flit", out_flit, '0);
        check("rst_out_src", W'(out_src), W'(0));
        cnt[1]   = 1;
        local_on = 1'b1;
        drive();
        #1;
        check("rst_consume_gated", W'(port_consume), W'(0));
        check("rst_local_gated", W'(local_ready), W'(0));
        cnt[1]   = 0;
        local_on = 1'b0;
        drive();
        @(negedge clk);
        rst = 1'b1;

        // Idle for 10 cycles.
        repeat (10) tick(7, 1'b0);

        // Round-robin across four ports with 3 flits each.
        for (int i = 0; i < 4; i++) cnt[i] = 3;
        drive();
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) tick(p, 1'b0);
        end
        check("rr_total", W'(grant_cnt), W'(12));
        tick(7, 1'b0);

        // Local burst cap against port 2 (pointer now at 0).
        local_on = 1'b1;
        cnt[2]   = 2;
        drive();
        for (int r = 0; r < 2; r++) begin
            repeat (4) tick(4, 1'b0);
            tick(2, 1'b0);
        end

        // Local alone: no cap.
        repeat (8) tick(4, 1'b0);
        local_on = 1'b0;
        drive();
        tick(7, 1'b0);

        // Backpressure with local and ports 0/1 pending; pointer at 3.
        local_on = 1'b1;
        cnt[0]   = 2;
        cnt[1]   = 2;
        drive();
        tick(4, 1'b0);
        tick(4, 1'b0);
        tick(7, 1'b1);
        tick(7, 1'b1);
        tick(4, 1'b0);
        tick(4, 1'b0);
        tick(0, 1'b0);
        tick(7, 1'b1);
        repeat (4) tick(4, 1'b0);
        tick(1, 1'b0);
        local_on = 1'b0;
        drive();
        tick(0, 1'b0);
        tick(1, 1'b0);
        tick(7, 1'b0);

        // Asynchronous reset in the middle of a port grant; pointer at 2.
        cnt[1] = 1;
        cnt[3] = 2;
        drive();
        tick(3, 1'b0);
        #1;
        check("pre_rst_consume", W'(port_consume), W'(4'b0010));
        rst = 1'b0;
        #1;
        exp_cnt   = '0;
        last_flit = '0;
        check("async_out_valid", W'(out_valid), W'(0));
        check("async_consume", W'(port_consume), W'(0));
        check("async_grant_cnt", W'(grant_cnt), W'(0));
        check("async_out_flit", out_flit, '0);
        @(posedge clk);
        #1;
        check("held_out_valid", W'(out_valid), W'(0));
        check("held_consume", W'(port_consume), W'(0));
        #2;
        rst = 1'b1;
        tick(1, 1'b0);
        tick(3, 1'b0);
        tick(7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reduce_port_arbiter.md
# reduce_port_arbiter

Scheduler for a node's reduction datapath. It shares the single reduce FIFO and reduce unit between five requesters: the four per-direction reduce FIFOs (xpos, ypos, xneg, yneg) and the local `reduce_me` injection. It replaces a fixed-priority tree plus a mux with a round-robin arbiter that bounds how long the local port can monopolise the path. Each cycle it issues at most one grant, pops the winning source and writes the flit into the reduce FIFO one cycle later.

## Interface
Parameters:
- `FlitChildWidth`, 85, width of flit plus children field (82 + lg_numprocs 3).
- `ValidBitPos`, 81, valid-bit index inside a flit.
- `MaxLocalBurst`, 4, maximum consecutive local grants while any port requests (≥1).
- `CntWidth`, 16, width of grant statistics counter.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `port_empty`  in  4  empty flags of reduce FIFOs; bit0 xpos, bit1 ypos, bit2 xneg, bit3 yneg.
- `port_head`  in  4*FlitChildWidth  head flits, port i at [i*FlitChildWidth +: FlitChildWidth].
- `port_consume`  out  4  one-hot pop strobe to port FIFOs (combinational).
- `local_flit`  in  FlitChildWidth  local reduce_me flit.
- `local_ready`  out  1  local flit accepted this cycle (combinational).
- `sink_afull`  in  1  reduce FIFO almost-full (≥1 free slot remains when asserted).
- `out_flit`  out  FlitChildWidth  registered flit to reduce FIFO.
- `out_valid`  out  1  registered write enable to reduce FIFO.
- `out_src`  out  3  registered source id: 0–3 port, 4 local.
- `grant_cnt`  out  CntWidth  total grants since reset, wraps.

## Operation
- Local request = `local_flit[ValidBitPos]`; port i request = `!port_empty[i]`.
- State: `rr_ptr` (2 b), `local_run` (saturating, 0..MaxLocalBurst), output registers, `grant_cnt`.
- Cycle with `sink_afull`=1: no grant; `port_consume`=0, `local_ready`=0; `rr_ptr`, `local_run` hold.
- Otherwise:
  - **Local** wins if local requests AND (`local_run` < MaxLocalBurst OR no port requests). Then `local_run`++ (saturating) and `rr_ptr` holds.
  - **Port** wins if some port requests and local does not win: first requesting port scanning `rr_ptr`, `rr_ptr`+1, … mod 4. That port's `port_consume` bit is asserted, `rr_ptr` ← winner+1 mod 4, `local_run` ← 0.
  - **Idle** if nothing requests: no grant. `local_run` ← 0 if local is not requesting, else holds.
- On a grant: `out_flit` ← winning flit unchanged, `out_src` ← id, `grant_cnt`++ (wraps 2^CntWidth−1 → 0).
- At most one of {`port_consume` bits, `local_ready`} is high per cycle.
- A port flit is never popped without a write: every `port_consume`/`local_ready` in cycle t pairs with `out_valid` in t+1.
- Local flits not accepted (`local_ready`=0) must be held stable by the source.

## Timing
- Grant decision and pop strobes are combinational from inputs and state in cycle t. `out_valid`/`out_flit`/`out_src` are visible at t+1. Latency is 1 cycle; throughput is 1 grant/cycle.
- `sink_afull` is sampled in cycle t, so one in-flight write at t+1 must fit. The sink sets afull with exactly one free slot.
- Reset (`rst`=0, asynchronous): `out_valid`=0, `out_flit`=0, `out_src`=0, `grant_cnt`=0, `rr_ptr`=0, `local_run`=0. Combinational outputs are forced to 0 while in reset.
- Reset mid-burst: the pending registered write is discarded (`out_valid` drops immediately). No further pops occur until `rst` deasserts. The first post-reset scan starts at xpos.
- When `out_valid`=0, `out_flit` holds its last value.

## Test plan
- **Reset/idle:** `rst`=0 then 1, all empty, local invalid for 10 cycles → `out_valid`=0, `grant_cnt`=0, no consume.
- **Round-robin:** all four ports hold 3 flits, local idle → `out_src` sequence 0,1,2,3,0,1,2,3,0,1,2,3. `grant_cnt`=12 afterwards. Each port sees exactly 3 consume pulses.
- **Local burst cap:** local valid continuously, port 2 non-empty, MaxLocalBurst=4 → sources 4,4,4,4,2,4,4,4,4,2…
- **Local alone:** local valid, all ports empty → local granted every cycle with no cap, `out_src`=4.
- **Backpressure:** `sink_afull` high for cycles 5–8 with traffic pending → no consume/local_ready in 5–8, `out_valid`=0 in 6–9. The interleaving of `out_src` resumes unchanged with no flit lost or duplicated.
- **Async reset mid-stream:** `rst` low between clock edges during a port grant → `out_valid` falls without waiting for an edge, the port FIFO is not popped, and the first grant after release comes from the lowest-indexed non-empty port.
